jk_reg_ctrl: RTL and testbench
==============================

JK_REG_CTRL -- requirements
Module: jk_reg_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  controller can accept a command.
REQ-006 cmd_op  input  2  00 LOAD, 01 COUNT, 10 SHIFT, 11 TOGGLE.
REQ-007 cmd_arg  input  WIDTH  LOAD data / COUNT steps / SHIFT amount / TOGGLE mask.
REQ-008 q  output  WIDTH  register contents.
REQ-009 busy  output  1  high in EXEC and DONE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 ovf  output  1  sticky count-overflow flag.

Function
REQ-012 Each q bit SHALL be a JK flip-flop cell; the controller drives only per-bit j,k (00 hold, 01 clear, 10 set, 11 toggle), never q directly.
REQ-013 FSM states SHALL be IDLE, EXEC, DONE; cmd_ready=1 only in IDLE.
REQ-014 Accept SHALL occur on an edge with cmd_valid=1 in IDLE (edge E0); cmd_op/cmd_arg latched, ovf cleared, state -> EXEC (or DONE if zero steps).
REQ-015 With N steps, q SHALL update on edges E1..EN, state -> DONE at EN, done=1 for exactly the cycle after EN, state -> IDLE at EN+1.
REQ-016 Outside EXEC, all j,k SHALL be 0 (q holds).
REQ-017 LOAD: N=1; j=arg, k=~arg; q=arg after E1.
REQ-018 COUNT: N=arg; each step increments q mod 2^WIDTH via j=k=carry-toggle mask (bit i toggles iff bits i-1..0 all 1).
REQ-019 COUNT step from all-ones SHALL wrap to 0 and set ovf; ovf stays high until next accept or reset.
REQ-020 SHIFT: N=min(arg, WIDTH); each step shifts q left by 1, LSB filled 0.
REQ-021 TOGGLE: N=1; j=k=arg.
REQ-022 COUNT or SHIFT with arg=0 SHALL go IDLE -> DONE at E0, q unchanged, done the following cycle.
REQ-023 cmd_valid while busy SHALL be ignored; no queuing; commands are not retained.
REQ-024 cmd_op/cmd_arg changes after E0 SHALL not affect the running command.

Reset
REQ-025 On any edge with reset=1: state=IDLE, q=0, busy=0, done=0, ovf=0, cmd_ready=1 from next cycle.
REQ-026 Reset SHALL dominate cmd_valid; no command accepted on a reset edge.
REQ-027 Reset during EXEC/DONE SHALL abort with no done pulse.

Configuration
REQ-028 Macro JK_REG_CTRL_SAT_EN defined: COUNT saturates; a step at all-ones holds q (j=k=0) and sets ovf; remaining steps still consume cycles (latency unchanged).
REQ-029 JK_REG_CTRL_SAT_EN undefined: COUNT wraps per REQ-019.

Verification
REQ-030 Reset, LOAD arg=4'hA at E0 -> q=4'hA after E1, done high cycle after E1, cmd_ready high after E2.
REQ-031 LOAD 4'hE, then COUNT 3 -> q F,0,1, ovf=1; with JK_REG_CTRL_SAT_EN q F,F,F, ovf=1, same latency.
REQ-032 LOAD 4'h3, SHIFT 2 -> q 6, C; SHIFT 0 -> done next cycle, q=4'hC; SHIFT 9 -> 4 steps, q=0.
REQ-033 LOAD 4'hF, TOGGLE 4'h5 -> q=4'hA; next accepted command clears ovf.
REQ-034 COUNT 10 from 0, reset at 4th EXEC edge -> q=0, busy=0, no done, cmd_ready=1 next cycle.
REQ-035 cmd_valid held high through a COUNT 3 with changing cmd_op -> only first command runs; next accept exactly one cycle after done.

Source files
------------

// File: rtl/jk_reg_ctrl.sv
// jk_reg_ctrl: command-driven register built from JK flip-flop cells (LOAD/COUNT/SHIFT/TOGGLE); define JK_REG_CTRL_SAT_EN for saturating COUNT
module jk_ff (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);
  // classic JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle
  always_ff @(posedge clk)
    if (reset) q <= 1'b0;
    else q <= (j & ~q) | (~k & q);
endmodule

module jk_reg_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             ovf
);
  localparam logic [1:0] OP_LOAD = 2'b00, OP_COUNT = 2'b01, OP_SHIFT = 2'b10;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] W_STEPS = WIDTH'(WIDTH);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state;
  logic [1:0] op;
  logic [WIDTH-1:0] arg, rem, n, j, k, inc_mask, cnt_mask, shl;
  logic step, all_ones;
  assign step = state == EXEC;
  assign all_ones = &q;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // step count for the incoming command and per-bit j/k drive for the running one
  always_comb begin
    n = cmd_op == OP_COUNT ? cmd_arg :
        cmd_op == OP_SHIFT ? (cmd_arg > W_STEPS ? W_STEPS : cmd_arg) : ONE;
    inc_mask = q ^ (q + ONE);
`ifdef JK_REG_CTRL_SAT_EN
    cnt_mask = all_ones ? '0 : inc_mask;
`else
    cnt_mask = inc_mask;
`endif
    shl = {q[WIDTH-2:0], 1'b0};
    j = !step ? '0 : op == OP_LOAD ? arg : op == OP_COUNT ? cnt_mask : op == OP_SHIFT ? shl : arg;
    k = !step ? '0 : op == OP_LOAD ? ~arg : op == OP_COUNT ? cnt_mask : op == OP_SHIFT ? ~shl : arg;
  end
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_ff u_ff (.clk(clk), .reset(reset), .j(j[g]), .k(k[g]), .q(q[g]));
  end
  // controller FSM: accept in IDLE, run rem steps in EXEC, one DONE cycle
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      op <= '0;
      arg <= '0;
      rem <= '0;
      ovf <= 1'b0;
    end else if (state == IDLE) begin
      if (cmd_valid) begin
        op <= cmd_op;
        arg <= cmd_arg;
        rem <= n;
        ovf <= 1'b0;
        state <= n == '0 ? DONE : EXEC;
      end
    end else if (step) begin
      rem <= rem - ONE;
      if (op == OP_COUNT && all_ones) ovf <= 1'b1;
      if (rem == ONE) state <= DONE;
    end else state <= IDLE;
endmodule

// File: tb/tb_jk_reg_ctrl.sv
// tb_jk_reg_ctrl: directed self-checking bench for jk_reg_ctrl
module tb_jk_reg_ctrl;
  logic clk = 0, reset = 1, cmd_valid = 0, cmd_ready, busy, done, ovf;
  logic [1:0] cmd_op = 0;
  logic [3:0] cmd_arg = 0, q;
  int checks = 0, passes = 0;

  jk_reg_ctrl #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .q(q), .busy(busy), .done(done), .ovf(ovf));

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] arg);
    cmd_valid = 1; cmd_op = op; cmd_arg = arg;
    tick;
    cmd_valid = 0; cmd_op = op + 2'd1; cmd_arg = ~arg;
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s got %h expected %h", name, got, exp);
    else passes++;
  endtask

  task test_reset;
    reset = 1; tick; tick; reset = 0;
    chk("rst_q", q, 4'h0);
    chk("rst_flags", {busy, done, ovf, cmd_ready}, 4'b0001);
  endtask

  task test_load;
    issue(2'b00, 4'hA);
    chk("load_e0_flags", {busy, done, cmd_ready, 1'b0}, 4'b1000);
    tick;
    chk("load_q", q, 4'hA);
    chk("load_done", {busy, done, cmd_ready, 1'b0}, 4'b1100);
    tick;
    chk("load_idle", {busy, done, cmd_ready, 1'b0}, 4'b0010);
  endtask

  task test_count_wrap;
    logic [3:0] e2, e3;
`ifdef JK_REG_CTRL_SAT_EN
    e2 = 4'hF; e3 = 4'hF;
`else
    e2 = 4'h0; e3 = 4'h1;
`endif
    issue(2'b00, 4'hE); tick; tick;
    issue(2'b01, 4'h3);
    tick;
    chk("cnt_e1_q", q, 4'hF);
    chk("cnt_e1_ovf", {3'b0, ovf}, 4'h0);
    tick;
    chk("cnt_e2_q", q, e2);
    chk("cnt_e2_ovf", {3'b0, ovf}, 4'h1);
    tick;
    chk("cnt_e3_q", q, e3);
    chk("cnt_e3_done", {busy, done, 2'b0}, 4'b1100);
    tick;
    chk("cnt_sticky", {2'b0, ovf, cmd_ready}, 4'b0011);
  endtask

  task test_toggle;
    issue(2'b00, 4'hF);
    chk("tog_accept_clr_ovf", {3'b0, ovf}, 4'h0);
    tick; tick;
    issue(2'b11, 4'h5); tick;
    chk("tog_q", q, 4'hA);
    chk("tog_done", {3'b0, done}, 4'h1);
    tick;
  endtask

  task test_shift;
    issue(2'b00, 4'h3); tick; tick;
    issue(2'b10, 4'h2);
    tick; chk("shl_e1", q, 4'h6);
    tick; chk("shl_e2", q, 4'hC);
    chk("shl_done", {3'b0, done}, 4'h1);
    tick;
    issue(2'b10, 4'h0);
    chk("shl0_done", {busy, done, cmd_ready, 1'b0}, 4'b1100);
    chk("shl0_q", q, 4'hC);
    tick;
    chk("shl0_idle", {busy, done, cmd_ready, 1'b0}, 4'b0010);
    issue(2'b10, 4'h9);
    tick; chk("shl9_e1", q, 4'h8);
    tick; tick;
    chk("shl9_e3_busy", {busy, done, 2'b0}, 4'b1000);
    tick;
    chk("shl9_e4", {q}, 4'h0);
    chk("shl9_done", {busy, done, 2'b0}, 4'b1100);
    tick;
  endtask

  task test_reset_abort;
    issue(2'b00, 4'h0); tick; tick;
    issue(2'b01, 4'hA);
    tick; tick; tick;
    chk("abort_e3_q", q, 4'h3);
    reset = 1; tick; reset = 0;
    chk("abort_q", q, 4'h0);
    chk("abort_flags", {busy, done, ovf, cmd_ready}, 4'b0001);
    tick;
    chk("abort_after", {busy, done, ovf, cmd_ready}, 4'b0001);
  endtask

  task test_back_to_back;
    cmd_valid = 1; cmd_op = 2'b01; cmd_arg = 4'h3;
    tick;
    cmd_op = 2'b10; cmd_arg = 4'h7;
    tick; chk("b2b_e1", q, 4'h1);
    cmd_op = 2'b11;
    tick; chk("b2b_e2", q, 4'h2);
    cmd_op = 2'b00;
    tick; chk("b2b_e3", q, 4'h3);
    chk("b2b_done", {busy, done, cmd_ready, 1'b0}, 4'b1100);
    cmd_arg = 4'h9;
    tick;
    chk("b2b_idle_q", q, 4'h3);
    chk("b2b_ready", {busy, done, cmd_ready, 1'b0}, 4'b0010);
    tick;
    cmd_valid = 0;
    chk("b2b_reaccept", {busy, done, cmd_ready, 1'b0}, 4'b1000);
    tick;
    chk("b2b_load_q", q, 4'h9);
    tick;
  endtask

  initial begin
    test_reset;
    test_load;
    test_count_wrap;
    test_toggle;
    test_shift;
    test_reset_abort;
    test_back_to_back;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
